// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned OPC_BITS    = 4;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [OPC_BITS-1:0] OP_BRANCH = 4'b0010;
  localparam logic [1:0]          BHT_INIT  = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetchState_e;

  function automatic logic isBranch(input logic [OPC_BITS-1:0] opcode);
    return opcode == OP_BRANCH;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read channel: request/address out, ack/data back.
interface fetch_if #(
  parameter int unsigned DBITS = 32
);

  logic             imem_req;
  logic [DBITS-1:0] imem_addr;
  logic             imem_ack;
  logic [DBITS-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_bht.sv
// Branch history table: 2-bit saturating counters, one async read, one training port.
module fetch_bht
  import fetch_pkg::*;
#(
  parameter int unsigned BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BHT_BITS-1:0] rdIdx,
  output logic [1:0]          rdCtr_c,
  input  logic                updEn,
  input  logic [BHT_BITS-1:0] updIdx,
  input  logic                updTaken
);

  localparam int unsigned ENTRIES = 2 ** BHT_BITS;

  logic [1:0] ctr [ENTRIES];

  // Reads see the pre-update value when an update hits the same entry.
  assign rdCtr_c = ctr[rdIdx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr[i] <= BHT_INIT;
      end
    end else if (updEn) begin
      if (updTaken && (ctr[updIdx] != 2'b11)) begin
        ctr[updIdx] <= ctr[updIdx] + 2'd1;
      end else if (!updTaken && (ctr[updIdx] != 2'b00)) begin
        ctr[updIdx] <= ctr[updIdx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, predicts branches
// and writes the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      DBITS    = 32,
  parameter int unsigned      BHT_BITS = 6,
  parameter logic [DBITS-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  fetch_if.master          imem,
  input  logic             stall,
  input  logic             redirect,
  input  logic [DBITS-1:0] redirect_pc,
  input  logic             bp_update,
  input  logic [DBITS-1:0] bp_pc,
  input  logic             bp_taken,
  output logic             IF_wrt_en,
  output logic [DBITS-1:0] instWord,
  output logic [DBITS-1:0] pcIncremented,
  output logic [DBITS-1:0] brBaseOffset,
  output logic             prediction
);

  fetchState_e      state, stateNext;
  logic [DBITS-1:0] pc, pcNext;
  logic             squash, squashNext;
  logic             capture;
  logic             addrLoad;
  logic [DBITS-1:0] seqPc;
  logic [DBITS-1:0] branchOffset;
  logic [DBITS-1:0] targetPc;
  logic [1:0]       bhtCtr;
  logic             unusedBits;

  fetch_bht #(
    .BHT_BITS (BHT_BITS)
  ) u_bht (
    .clk      (clk),
    .rst_n    (reset),
    .rdIdx    (pc[BHT_BITS+1:2]),
    .rdCtr_c  (bhtCtr),
    .updEn    (bp_update),
    .updIdx   (bp_pc[BHT_BITS+1:2]),
    .updTaken (bp_taken)
  );

  assign unusedBits = ^{bp_pc[DBITS-1:BHT_BITS+2], bp_pc[1:0], bhtCtr[0]};

  // Sequential and branch-target addresses for the word arriving from memory.
  assign seqPc        = pc + DBITS'(INSTR_BYTES);
  assign branchOffset = {{(DBITS-18){imem.imem_rdata[15]}}, imem.imem_rdata[15:0], 2'b00};
  assign targetPc     = seqPc + branchOffset;

  assign IF_wrt_en = (state == VALID) & ~stall & ~redirect;

  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    squashNext = squash;
    capture    = 1'b0;
    addrLoad   = 1'b0;

    unique case (state)
      IDLE: begin
        stateNext = REQ;
        addrLoad  = 1'b1;
      end
      REQ: begin
        if (imem.imem_ack) begin
          addrLoad = 1'b1;
          if (squash || redirect) begin
            squashNext = 1'b0;
          end else begin
            capture   = 1'b1;
            stateNext = VALID;
          end
        end else if (redirect) begin
          // The outstanding read cannot be aborted; mark its data stale.
          squashNext = 1'b1;
        end
      end
      VALID: begin
        if (!stall) begin
          pcNext    = prediction ? brBaseOffset : pcIncremented;
          stateNext = REQ;
          addrLoad  = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    if (redirect) begin
      pcNext = redirect_pc;
      if (state != REQ) begin
        stateNext = REQ;
        addrLoad  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      squash <= 1'b0;
    end else begin
      state  <= stateNext;
      pc     <= pcNext;
      squash <= squashNext;
    end
  end

  // Memory request and IF/ID payload registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      instWord       <= '0;
      pcIncremented  <= '0;
      brBaseOffset   <= '0;
      prediction     <= 1'b0;
    end else begin
      imem.imem_req <= (stateNext == REQ);
      if (addrLoad) begin
        imem.imem_addr <= pcNext;
      end
      if (capture) begin
        instWord      <= imem.imem_rdata;
        pcIncremented <= seqPc;
        brBaseOffset  <= targetPc;
        prediction    <= isBranch(imem.imem_rdata[DBITS-1 -: OPC_BITS]) & bhtCtr[1];
      end
    end
  end

endmodule
